// File: rtl/asip_isa_pkg.sv
// ISA definitions shared by the instruction loader and the pipeline decode stage:
// instruction classes, opcode constants, field positions and the opcode encoder.
package asip_isa_pkg;

  typedef enum logic [1:0] {
    CLS_IMM  = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_JUMP = 2'd2,
    CLS_MEM  = 2'd3
  } cls_e;

  localparam logic [3:0] OPC_IMM  = 4'b0000;
  localparam logic [3:0] OPC_JMP0 = 4'b1000;
  localparam logic [3:0] OPC_JMP1 = 4'b1001;
  localparam logic [3:0] OPC_JMP2 = 4'b1010;
  localparam logic [3:0] OPC_ST   = 4'b1100;
  localparam logic [3:0] OPC_LD   = 4'b1101;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int REG_HI = 11;
  localparam int REG_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } ldr_state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] opc;
  } opc_t;

  function automatic opc_t encode_opc(input cls_e cls, input logic [2:0] op);
    opc_t r;
    r.legal = 1'b1;
    r.opc   = OPC_IMM;
    unique case (cls)
      CLS_IMM:  r.opc = OPC_IMM;
      CLS_ALU: begin
        r.opc   = {1'b0, op};
        r.legal = (op != 3'd0);
      end
      CLS_JUMP: begin
        unique case (op)
          3'd0:    r.opc = OPC_JMP0;
          3'd1:    r.opc = OPC_JMP1;
          3'd2:    r.opc = OPC_JMP2;
          default: r.legal = 1'b0;
        endcase
      end
      CLS_MEM: begin
        unique case (op)
          3'd0:    r.opc = OPC_ST;
          3'd1:    r.opc = OPC_LD;
          default: r.legal = 1'b0;
        endcase
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Encoded-word FIFO; DEPTH must be a power of two, at least 2. Extra pointer
// bit distinguishes full from empty.
module instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW:0]      wr_q, wr_d, rd_q, rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head  = mem_q[rd_q[PW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) begin
      mem_d[wr_q[PW-1:0]] = din;
      wr_d = wr_q + ONE;
    end
    if (pop && !empty) rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts instruction field bundles, encodes legal ones into 16-bit words and
// streams them into instruction memory from a base address.
module instr_encode_loader
  import asip_isa_pkg::*;
#(
  parameter int N     = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          fld_valid,
  output logic          fld_ready,
  input  logic [1:0]    fld_class,
  input  logic [2:0]    fld_op,
  input  logic [3:0]    fld_reg,
  input  logic [7:0]    fld_imm,
  input  logic          fld_last,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [N-1:0]  imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_cnt
);
  ldr_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;

  opc_t          dec;
  logic [N-1:0]  enc;
  logic [N-1:0]  head;
  logic          full, empty, accept, push, pop;

  assign dec    = encode_opc(cls_e'(fld_class), fld_op);
  assign accept = fld_valid && fld_ready;
  assign push   = accept && dec.legal;
  assign pop    = imem_we && imem_ready;

  always_comb begin
    enc                 = '0;
    enc[OPC_HI:OPC_LO]  = dec.opc;
    enc[REG_HI:REG_LO]  = fld_reg;
    enc[IMM_HI:IMM_LO]  = fld_imm;
  end

  instr_fifo #(.WIDTH(N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (enc),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && fld_last) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready looks only at fullness so it never combinationally depends on imem_ready.
  always_comb begin
    fld_ready = (state_q == S_RUN) && !full;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (state_q == S_IDLE && start) begin
      addr_d = base_addr;
      cnt_d  = '0;
      err_d  = 1'b0;
    end else begin
      if (pop) begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
      end
      if (accept && !dec.legal) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign imem_we    = !empty;
  assign imem_wdata = empty ? '0 : head;
  assign imem_addr  = addr_q;
  assign word_cnt   = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: driver pushes expected writes from a
// rule-level model, an independent monitor pops and compares on each memory write.
module tb_instr_encode_loader;
  localparam int N = 16, AW = 8, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          fld_valid = 1'b0;
  logic          fld_ready;
  logic [1:0]    fld_class = '0;
  logic [2:0]    fld_op = '0;
  logic [3:0]    fld_reg = '0;
  logic [7:0]    fld_imm = '0;
  logic          fld_last = 1'b0;
  logic          imem_we;
  logic          imem_ready = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [N-1:0]  imem_wdata;
  logic          busy, done, err;
  logic [AW:0]   word_cnt;

  instr_encode_loader #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .fld_valid(fld_valid), .fld_ready(fld_ready), .fld_class(fld_class),
    .fld_op(fld_op), .fld_reg(fld_reg), .fld_imm(fld_imm), .fld_last(fld_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } wr_t;

  wr_t sbq[$];
  int  tests = 0, fails = 0;
  int  m_addr, m_cnt, acc_cnt;
  bit  m_err;
  int  ready_mode = 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0: random backpressure, 1: always ready, 2: stalled
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       imem_ready = ($urandom_range(0, 3) != 0);
      1:       imem_ready = 1'b1;
      default: imem_ready = 1'b0;
    endcase
  end

  // Monitor: every we&ready cycle must match the oldest expected write.
  initial begin
    bit            stall;
    logic [AW-1:0] ha;
    logic [N-1:0]  hd;
    wr_t           e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (stall && imem_we === 1'b1) begin
        chk("hold_addr", 32'(imem_addr), 32'(ha));
        chk("hold_data", 32'(imem_wdata), 32'(hd));
      end
      stall = (imem_we === 1'b1) && (imem_ready === 1'b0);
      ha = imem_addr;
      hd = imem_wdata;
      if (imem_we === 1'b1 && imem_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", imem_addr, imem_wdata);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(e.addr));
          chk("wr_data", 32'(imem_wdata), 32'(e.data));
        end
      end
    end
  end

  // Reference encoding from the ISA rules.
  task automatic ref_word(int cls, int op, int rg, int imm, output bit legal, output int w);
    int opc;
    legal = 1'b1;
    opc = 0;
    case (cls)
      0: opc = 0;
      1: begin legal = (op != 0); opc = op;      end
      2: begin legal = (op <= 2); opc = 8 + op;  end
      default: begin legal = (op <= 1); opc = 12 + op; end
    endcase
    w = opc * 4096 + rg * 256 + imm;
  endtask

  task automatic do_start(int base);
    start = 1'b1;
    base_addr = AW'(base);
    m_addr = base; m_cnt = 0; m_err = 1'b0; acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(int cls, int op, int rg, int imm, bit last, bit rnd_start);
    bit legal, got;
    int w;
    wr_t e;
    got = 1'b0;
    fld_class = 2'(cls); fld_op = 3'(op); fld_reg = 4'(rg); fld_imm = 8'(imm);
    fld_last = last; fld_valid = 1'b1;
    if (rnd_start) begin
      start = ($urandom_range(0, 3) == 0);
      base_addr = AW'($urandom);
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (fld_ready === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    fld_valid = 1'b0;
    start = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL accept_timeout: fld_ready never rose, required within 200 cycles");
    end else begin
      acc_cnt++;
      ref_word(cls, op, rg, imm, legal, w);
      if (legal) begin
        e.addr = AW'(m_addr); e.data = N'(w);
        sbq.push_back(e);
        m_addr = (m_addr + 1) % (1 << AW);
        m_cnt++;
      end else m_err = 1'b1;
    end
  endtask

  task automatic wait_done(string tag);
    bit got;
    got = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s_done_timeout: done never pulsed, required within 300 cycles", tag);
    end else begin
      chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(m_cnt));
      chk({tag, "_err"}, 32'(err), 32'(m_err));
      chk({tag, "_sb_drained"}, 32'(sbq.size()), 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 0);
      chk({tag, "_busy_idle"}, 32'(busy), 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_fld_ready"}, 32'(fld_ready), 0);
    chk({tag, "_imem_we"}, 32'(imem_we), 0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 0);
    chk({tag, "_imem_wdata"}, 32'(imem_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single IMM word
    do_start(8'h10);
    send(0, 0, 4'h4, 8'h2A, 1'b1, 1'b0);
    wait_done("imm");

    // ALU / JUMP / MEM encodings
    do_start(0);
    send(1, 5, 3, 0, 1'b0, 1'b0);
    send(2, 2, 0, 0, 1'b0, 1'b0);
    send(3, 1, 9, 8'h80, 1'b1, 1'b0);
    wait_done("mix");

    // Backpressure: FIFO fills after 4 accepts while memory stalls
    ready_mode = 2;
    @(posedge clk); #1;
    do_start(8'h30);
    fork
      for (int i = 0; i < 6; i++) send(i % 2, 1 + i, i, 8'h11 * i, (i == 5), 1'b0);
      begin
        repeat (8) @(negedge clk);
        chk("bp_fld_ready_full", 32'(fld_ready), 0);
        chk("bp_accepts_full", 32'(acc_cnt), 4);
        chk("bp_we_stalled", 32'(imem_we), 1);
        ready_mode = 1;
      end
    join
    wait_done("bp");

    // Illegal-only session, then start clears err
    do_start(8'h50);
    send(2, 3, 1, 1, 1'b0, 1'b0);
    send(1, 0, 2, 2, 1'b1, 1'b0);
    wait_done("illegal");
    chk("illegal_err_sticky", 32'(err), 1);
    do_start(8'h60);
    @(negedge clk);
    chk("start_clears_err", 32'(err), 0);
    @(posedge clk); #1;
    send(0, 0, 1, 8'h01, 1'b1, 1'b0);
    wait_done("after_err");

    // Address wrap
    do_start(8'hFF);
    send(0, 0, 2, 8'h33, 1'b0, 1'b0);
    send(3, 0, 5, 8'h44, 1'b1, 1'b0);
    wait_done("wrap");

    // Reset while draining three queued words
    ready_mode = 2;
    @(posedge clk); #1;
    do_start(8'h40);
    send(0, 0, 1, 1, 1'b0, 1'b0);
    send(1, 7, 2, 2, 1'b0, 1'b0);
    send(3, 0, 3, 3, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_fld_ready", 32'(fld_ready), 0);
    chk("drain_we", 32'(imem_we), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 1;
    @(negedge clk);
    chk("post_rst_we", 32'(imem_we), 0);
    @(posedge clk); #1;
    do_start(8'h20);
    send(0, 0, 7, 8'h77, 1'b1, 1'b0);
    wait_done("post_rst");

    // Randomized sessions with backpressure and stray start pulses
    ready_mode = 0;
    for (int s = 0; s < 12; s++) begin
      do_start(int'($urandom_range(0, 255)));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15),
             $urandom_range(0, 255), (i == n - 1), 1'b1);
      wait_done("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 Parameter N, default 16, instruction word width; fixed at 16 for the current ISA.
REQ-002 Parameter AW, default 8, instruction-memory address width.
REQ-003 Parameter DEPTH, default 4, encoded-word FIFO depth (power of two).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed below in order.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a load session at base_addr.
- base_addr  in  AW  first write address.
- fld_valid  in  1  field bundle valid.
- fld_ready  out  1  field bundle accepted when valid&ready.
- fld_class  in  2  0=IMM, 1=ALU, 2=JUMP, 3=MEM.
- fld_op  in  3  sub-operation.
- fld_reg  in  4  destination register (bit2 = 1 scalar, 0 vector).
- fld_imm  in  8  immediate.
- fld_last  in  1  final bundle of the session.
- imem_we  out  1  write strobe.
- imem_ready  in  1  memory accepts the write when we&ready.
- imem_addr  out  AW  write address.
- imem_wdata  out  N  encoded instruction.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky illegal-encoding flag, cleared by start.
- word_cnt  out  AW+1  words written this session.

Function
REQ-005 Encoding SHALL be wdata = {opc[3:0], fld_reg, fld_imm}.
REQ-006 opc values:
- IMM: 4'b0000.
- ALU: {1'b0, fld_op}, with fld_op 1..7 legal.
- JUMP: 4'b1000 (op 0), 4'b1001 (op 1), 4'b1010 (op 2).
- MEM: 4'b1100 store (op 0), 4'b1101 load (op 1).
REQ-007 Illegal bundles SHALL be consumed, not written, and set err. Illegal bundles are ALU op 0, JUMP op 3..7, and MEM op 2..7.
REQ-008 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-009 IDLE transitions to RUN on start; on that transition the address counter loads base_addr, word_cnt clears and err clears.
REQ-010 In RUN, fld_ready SHALL equal (FIFO not full), with no dependence on the same-cycle pop.
REQ-011 An accepted bundle with fld_last=1 SHALL move RUN to DRAIN, and fld_ready SHALL drop in DRAIN.
REQ-012 DRAIN SHALL move to DONE when the FIFO is empty and no write is pending; DONE lasts one cycle with done=1, then returns to IDLE.
REQ-013 A legal bundle accepted in cycle t SHALL be pushed at edge t; it appears on imem_wdata/imem_we from cycle t+1 if the FIFO was empty.
REQ-014 imem_we SHALL equal (FIFO not empty). The head pops, the address increments and word_cnt increments on we&imem_ready.
REQ-015 While imem_ready=0, imem_addr and imem_wdata SHALL hold stable.
REQ-016 The address SHALL wrap from 2^AW-1 to 0 without error.
REQ-017 start SHALL be ignored when the state is not IDLE.
REQ-018 A final bundle (fld_last=1) that is illegal SHALL still end the session.

Reset
REQ-019 rst_n low SHALL force the following immediately, regardless of state, and discard FIFO contents:
- state IDLE.
- fld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
- busy=0, done=0, err=0, word_cnt=0.

Structure
REQ-020 Package asip_isa_pkg SHALL hold the class enum, the opc constants, and the field bit positions [15:12], [11:8] and [7:0]; the pipeline decode stage SHALL share these definitions.
REQ-021 The FIFO SHALL be a sub-module named instr_fifo, with parameters width and depth and ports push, pop, full, empty and head.

Verification
REQ-022 start, base_addr=8'h10, then IMM reg=4'h4 imm=8'h2A (last) -> one write, addr 8'h10, wdata 16'h042A, then done; word_cnt=1.
REQ-023 Bundles ALU op5 reg3 imm0, JUMP op2, MEM op1 reg9 imm8'h80 (last) -> wdata 16'h5300, 16'hA000, 16'hD980 at addr 0,1,2.
REQ-024 imem_ready held 0 for 6 cycles during a stream of 6 bundles -> fld_ready drops after 4 accepts, writes hold stable, all 6 words land in order.
REQ-025 JUMP op3 then ALU op0 (last) -> no writes, err=1, done pulses; the next start clears err.
REQ-026 base_addr=8'hFF with 2 bundles -> writes at 8'hFF then 8'h00.
REQ-027 Assert rst_n=0 in DRAIN with 3 words queued -> no further imem_we, all outputs at reset values, and start then works normally.
